sccb_target_regs: RTL and testbench

SCCB/I2C target (responder) with an internal 8-bit register file: the other end of the bus driven by `i2c_master_wrapper`. It decodes start/stop, matches a 7-bit slave address, accepts a register pointer, and then either stores write bytes (with auto-increment) or returns read bytes. It serves as an OV7670 SCCB stand-in for loopback and simulation of the ROM-driven configuration path, and exposes every accepted write to the fabric.

---
 rtl/sccb_target_regs.sv | 253 +++++++++++++++++++++++++
 tb/tb_sccb_target_regs.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_target_regs.sv
// sccb_target_regs: SCCB/I2C target with an internal byte-wide register file.
// Decodes START/STOP, matches a 7-bit address, takes a register pointer, then
// stores write bytes (auto-increment) or returns read bytes. Every accepted
// write is also presented to the fabric as a one-cycle pulse.
module sccb_target_regs #(
  parameter logic [6:0] p_slave_addr  = 7'h21,
  parameter int         p_addr_width  = 8,
  parameter int         p_hold_cycles = 4,
  parameter int         p_sccb_mode   = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_scl,
  input  logic                    i_sda,
  output logic                    o_sda_oe,
  output logic                    o_wr_valid,
  output logic [p_addr_width-1:0] o_wr_addr,
  output logic [7:0]              o_wr_data,
  input  logic [p_addr_width-1:0] i_rd_addr,
  output logic [7:0]              o_rd_data,
  output logic                    o_busy
);

  localparam int Depth = 2 ** p_addr_width;
  localparam int HoldW = (p_hold_cycles > 1) ? $clog2(p_hold_cycles) : 1;
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(p_hold_cycles - 1);
  // Both SCCB and I2C end a read silently when the master withholds its ACK.
  localparam bit SccbMode = (p_sccb_mode != 0);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  state_t state, state_next;

  logic [1:0] scl_sync, sda_sync;
  logic       scl_prev, sda_prev;
  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall, start_det, stop_det;

  logic [2:0]              cnt;
  logic [7:0]              shreg;
  logic [7:0]              byte_in;
  logic [p_addr_width-1:0] ptr, ptr_plus, ptr_from_byte;
  logic [7:0]              mem [Depth];

  logic             hold_act, hold_val, drive_val;
  logic [HoldW-1:0] hold_cnt;

  logic bit_adv, cnt_clr, ptr_load, ptr_inc, ld_cur, ld_next;
  logic wr_en, busy_set, busy_clr;

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_prev;
  assign scl_fall  = ~scl_s & scl_prev;
  assign start_det = scl_s & sda_prev & ~sda_s;
  assign stop_det  = scl_s & ~sda_prev & sda_s;

  assign byte_in       = {shreg[6:0], sda_s};
  assign ptr_plus      = ptr + 1'b1;
  assign ptr_from_byte = p_addr_width'(byte_in);

  // Bring the asynchronous bus pins into the clock domain; idle bus is high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], i_scl};
      sda_sync <= {sda_sync[0], i_sda};
      scl_prev <= scl_sync[1];
      sda_prev <= sda_sync[1];
    end
  end

  // Protocol state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next state and datapath strobes; STOP beats START beats bit sampling.
  always_comb begin
    state_next = state;
    bit_adv    = 1'b0;
    cnt_clr    = 1'b0;
    ptr_load   = 1'b0;
    ptr_inc    = 1'b0;
    ld_cur     = 1'b0;
    ld_next    = 1'b0;
    wr_en      = 1'b0;
    busy_set   = 1'b0;
    busy_clr   = 1'b0;
    if (stop_det) begin
      state_next = IDLE;
      busy_clr   = 1'b1;
    end else if (start_det) begin
      state_next = ADDR;
      cnt_clr    = 1'b1;
    end else if (scl_rise) begin
      case (state)
        ADDR: begin
          bit_adv = 1'b1;
          if (cnt == 3'd7) begin
            if (byte_in[7:1] == p_slave_addr) begin
              state_next = ADDR_ACK;
              busy_set   = 1'b1;
            end else begin
              state_next = IDLE;
              busy_clr   = 1'b1;
            end
          end
        end
        ADDR_ACK: begin
          cnt_clr = 1'b1;
          if (shreg[0]) begin
            state_next = RDATA;
            ld_cur     = 1'b1;
          end else begin
            state_next = REG;
          end
        end
        REG: begin
          bit_adv = 1'b1;
          if (cnt == 3'd7) begin
            ptr_load   = 1'b1;
            state_next = REG_ACK;
          end
        end
        REG_ACK: begin
          cnt_clr    = 1'b1;
          state_next = WDATA;
        end
        WDATA: begin
          bit_adv = 1'b1;
          if (cnt == 3'd7) begin
            wr_en      = 1'b1;
            ptr_inc    = 1'b1;
            state_next = WDATA_ACK;
          end
        end
        WDATA_ACK: begin
          cnt_clr    = 1'b1;
          state_next = WDATA;
        end
        RDATA: begin
          bit_adv = 1'b1;
          if (cnt == 3'd7) state_next = RDATA_ACK;
        end
        RDATA_ACK: begin
          cnt_clr = 1'b1;
          if (!sda_s) begin
            ptr_inc    = 1'b1;
            ld_next    = 1'b1;
            state_next = RDATA;
          end else if (SccbMode) begin
            state_next = IDLE;
            busy_clr   = 1'b1;
          end else begin
            state_next = IDLE;
            busy_clr   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // SDA level to present after the next SCL fall, chosen by the current phase.
  always_comb begin
    drive_val = 1'b0;
    case (state)
      ADDR_ACK, REG_ACK, WDATA_ACK: drive_val = 1'b1;
      RDATA:                        drive_val = ~shreg[7];
      default:                      drive_val = 1'b0;
    endcase
  end

  // Bit counter, shift register, pointer, busy flag and fabric write strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt        <= '0;
      shreg      <= '0;
      ptr        <= '0;
      o_busy     <= 1'b0;
      o_wr_valid <= 1'b0;
      o_wr_addr  <= '0;
      o_wr_data  <= '0;
    end else begin
      if (cnt_clr)      cnt <= '0;
      else if (bit_adv) cnt <= cnt + 3'd1;

      if (ld_cur)       shreg <= mem[ptr];
      else if (ld_next) shreg <= mem[ptr_plus];
      else if (bit_adv) shreg <= byte_in;

      if (ptr_load)     ptr <= ptr_from_byte;
      else if (ptr_inc) ptr <= ptr_plus;

      if (busy_clr)      o_busy <= 1'b0;
      else if (busy_set) o_busy <= 1'b1;

      o_wr_valid <= wr_en;
      if (wr_en) begin
        o_wr_addr <= ptr;
        o_wr_data <= byte_in;
      end
    end
  end

  // SDA drive changes land a fixed hold time after each detected SCL fall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sda_oe <= 1'b0;
      hold_act <= 1'b0;
      hold_val <= 1'b0;
      hold_cnt <= '0;
    end else if (start_det || stop_det) begin
      o_sda_oe <= 1'b0;
      hold_act <= 1'b0;
    end else if (scl_fall) begin
      hold_act <= 1'b1;
      hold_val <= drive_val;
      hold_cnt <= HoldLoad;
    end else if (hold_act) begin
      if (hold_cnt == '0) begin
        o_sda_oe <= hold_val;
        hold_act <= 1'b0;
      end else begin
        hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

  // Register file storage; cleared by reset, written on each accepted byte.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[ptr] <= byte_in;
    end
  end

  // Fabric read port, one cycle latency; a same-cycle write shows up next read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_rd_data <= '0;
    else          o_rd_data <= mem[i_rd_addr];
  end

endmodule

// File: tb/tb_sccb_target_regs.sv
// tb_sccb_target_regs: bus-level bench acting as SCCB master, with a plain
// array model of the register file and a queue of expected write pulses.
module tb_sccb_target_regs;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic       bus_sda;
  logic       sda_oe;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_addr = 8'h00;
  logic [7:0] rd_data;
  logic       busy;

  int check_count = 0;
  int error_count = 0;

  logic [7:0]  model_mem [256];
  logic [15:0] got_q [$];
  logic [15:0] exp_q [$];
  logic [7:0]  payload [8];

  assign bus_sda = ~(m_low | sda_oe);

  sccb_target_regs dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_scl      (scl),
    .i_sda      (bus_sda),
    .o_sda_oe   (sda_oe),
    .o_wr_valid (wr_valid),
    .o_wr_addr  (wr_addr),
    .o_wr_data  (wr_data),
    .i_rd_addr  (rd_addr),
    .o_rd_data  (rd_data),
    .o_busy     (busy)
  );

  // System clock.
  always #5 clk = ~clk;

  // Record every fabric write pulse seen on the output.
  always @(negedge clk) begin
    if (rst_n && wr_valid) got_q.push_back({wr_addr, wr_data});
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_out(input logic b);
    wait_clk(10); m_low = ~b;
    wait_clk(10); scl = 1'b1;
    wait_clk(12); scl = 1'b0;
  endtask

  task automatic bit_in(output logic b);
    wait_clk(10); m_low = 1'b0;
    wait_clk(10); scl = 1'b1;
    wait_clk(6);  b = bus_sda;
    wait_clk(6);  scl = 1'b0;
  endtask

  task automatic bus_start();
    m_low = 1'b1;
    wait_clk(10); scl = 1'b0;
  endtask

  task automatic bus_restart();
    wait_clk(10); m_low = 1'b0;
    wait_clk(10); scl = 1'b1;
    wait_clk(10); m_low = 1'b1;
    wait_clk(10); scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(10); m_low = 1'b1;
    wait_clk(10); scl = 1'b1;
    wait_clk(10); m_low = 1'b0;
    wait_clk(20);
  endtask

  task automatic write_byte(input logic [7:0] v, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) bit_out(v[i]);
    bit_in(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] v, input logic master_ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_in(b);
      v[i] = b;
    end
    bit_out(~master_ack);
  endtask

  task automatic fabric_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk); rd_addr = a;
    @(negedge clk); d = rd_data;
  endtask

  task automatic compare_pulses(input string tag);
    checkOutput({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      checkOutput(tag, {16'h0, got_q[i]}, {16'h0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  // Full write transaction: address, pointer, n payload bytes, STOP.
  task automatic write_txn(input logic [7:0] reg_addr, input int n);
    logic       ack;
    logic [7:0] a;
    bus_start();
    write_byte(8'h42, ack); checkOutput("wr_addr_ack", ack, 1'b1);
    checkOutput("wr_busy", busy, 1'b1);
    write_byte(reg_addr, ack); checkOutput("wr_reg_ack", ack, 1'b1);
    for (int i = 0; i < n; i++) begin
      write_byte(payload[i], ack); checkOutput("wr_data_ack", ack, 1'b1);
      a = reg_addr + 8'(i);
      model_mem[a] = payload[i];
      exp_q.push_back({a, payload[i]});
    end
    bus_stop();
    checkOutput("wr_busy_after_stop", busy, 1'b0);
    compare_pulses("wr_pulse");
  endtask

  // Pointer write, repeated START, n-byte read ending in NACK, STOP.
  task automatic read_txn(input logic [7:0] reg_addr, input int n);
    logic       ack;
    logic [7:0] d;
    bus_start();
    write_byte(8'h42, ack); checkOutput("rd_waddr_ack", ack, 1'b1);
    write_byte(reg_addr, ack); checkOutput("rd_reg_ack", ack, 1'b1);
    bus_restart();
    write_byte(8'h43, ack); checkOutput("rd_raddr_ack", ack, 1'b1);
    for (int i = 0; i < n; i++) begin
      read_byte(d, i < n - 1);
      checkOutput("rd_data", d, model_mem[reg_addr + 8'(i)]);
    end
    wait_clk(15);
    checkOutput("rd_release_after_nack", sda_oe, 1'b0);
    checkOutput("rd_idle_after_nack", busy, 1'b0);
    bus_stop();
    checkOutput("rd_no_pulse", got_q.size(), 0);
    got_q.delete();
  endtask

  // Transaction addressed elsewhere: no ACK, no busy, no write.
  task automatic foreign_txn(input logic [6:0] addr7);
    logic ack;
    bus_start();
    write_byte({addr7, 1'b0}, ack);
    checkOutput("foreign_no_ack", ack, 1'b0);
    checkOutput("foreign_not_busy", busy, 1'b0);
    write_byte(8'h5C, ack);
    bus_stop();
    checkOutput("foreign_no_pulse", got_q.size(), 0);
    got_q.delete();
  endtask

  // One random transaction chosen among write burst, read burst, foreign address.
  task automatic applyStimulus();
    int          kind, n;
    logic [7:0]  r;
    logic [6:0]  fa;
    kind = $urandom_range(0, 9);
    r    = 8'($urandom_range(0, 255));
    if (kind < 5) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) payload[i] = 8'($urandom_range(0, 255));
      write_txn(r, n);
    end else if (kind < 9) begin
      read_txn(r, $urandom_range(1, 3));
    end else begin
      fa = 7'($urandom_range(0, 127));
      if (fa == 7'h21) fa = 7'h22;
      foreign_txn(fa);
    end
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    logic [7:0] v;
    int         cnt;

    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;

    // Reset values while held in reset.
    wait_clk(4);
    checkOutput("rst_sda_oe", sda_oe, 1'b0);
    checkOutput("rst_wr_valid", wr_valid, 1'b0);
    checkOutput("rst_wr_addr", wr_addr, 8'h00);
    checkOutput("rst_wr_data", wr_data, 8'h00);
    checkOutput("rst_rd_data", rd_data, 8'h00);
    checkOutput("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    wait_clk(10);

    // Single write of 0x80 to register 0x12.
    payload[0] = 8'h80;
    write_txn(8'h12, 1);
    fabric_read(8'h12, d);
    checkOutput("fabric_rd_12", d, 8'h80);

    // Foreign address 0x42 is ignored.
    foreign_txn(7'h42);

    // Burst across the top of the register file.
    payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33;
    write_txn(8'hFE, 3);
    fabric_read(8'hFE, d); checkOutput("fabric_rd_fe", d, 8'h11);
    fabric_read(8'hFF, d); checkOutput("fabric_rd_ff", d, 8'h22);
    fabric_read(8'h00, d); checkOutput("fabric_rd_00", d, 8'h33);

    // Preload 0x0A/0x0B, then pointer write + repeated START + two-byte read.
    payload[0] = 8'h5A; payload[1] = 8'hA5;
    write_txn(8'h0A, 2);
    read_txn(8'h0A, 2);

    // STOP after five data bits: nothing written, next transaction normal.
    bus_start();
    write_byte(8'h42, ack); checkOutput("part_addr_ack", ack, 1'b1);
    write_byte(8'h30, ack); checkOutput("part_reg_ack", ack, 1'b1);
    v = 8'hC7;
    for (int i = 7; i >= 3; i--) bit_out(v[i]);
    bus_stop();
    checkOutput("part_no_pulse", got_q.size(), 0);
    checkOutput("part_idle", busy, 1'b0);
    fabric_read(8'h30, d); checkOutput("part_mem_30", d, model_mem[8'h30]);
    got_q.delete();
    payload[0] = 8'h77;
    write_txn(8'h31, 1);

    // Randomized traffic against the model.
    for (int t = 0; t < 16; t++) applyStimulus();
    for (int t = 0; t < 8; t++) begin
      v = 8'($urandom_range(0, 255));
      fabric_read(v, d);
      checkOutput("fabric_rand", d, model_mem[v]);
    end

    // ACK hold latency, then asynchronous reset while the ACK is driven.
    bus_start();
    v = 8'h42;
    for (int i = 7; i >= 0; i--) bit_out(v[i]);
    cnt = 0;
    while (!sda_oe && cnt < 40) begin
      wait_clk(1);
      cnt++;
    end
    checkOutput("ack_hold_latency", cnt, 7);
    checkOutput("ack_driving", sda_oe, 1'b1);
    wait_clk(2);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_sda_oe", sda_oe, 1'b0);
    checkOutput("arst_wr_valid", wr_valid, 1'b0);
    checkOutput("arst_wr_addr", wr_addr, 8'h00);
    checkOutput("arst_wr_data", wr_data, 8'h00);
    checkOutput("arst_rd_data", rd_data, 8'h00);
    checkOutput("arst_busy", busy, 1'b0);
    m_low = 1'b0;
    scl   = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    got_q.delete();
    wait_clk(10);
    fabric_read(8'h12, d); checkOutput("arst_mem_cleared", d, 8'h00);

    // Normal operation after reset, pointer starts from the new write.
    payload[0] = 8'h3C;
    write_txn(8'h44, 1);
    read_txn(8'h44, 1);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
